eth_mdio_responder: RTL
=======================

Name: eth_mdio_responder

Overview:
- PHY-side MII management (MDIO) slave: the counterpart of the MAC station's management shift register.
- Samples Mdc/MdioIn in the Clk domain and decodes IEEE 802.3 clause-22 frames: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Write frames are turned into single-cycle register-write strobes. Read frames fetch register data and drive it back on MDIO.
- Used as the PHY model/responder in the Ethernet MII management path and its bench.

Parameters:
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST is accepted (1..32).
- SYNC_STAGES, 2, synchroniser depth for Mdc and MdioIn (>=2).
- BCAST_EN, 0, 1 = also respond to PHYAD 5'h00.

Ports:
- Clk  input  1  host clock; frequency >= 8x Mdc.
- Resetn  input  1  asynchronous, active-low reset.
- PhyAddr  input  5  this PHY's address; static during frames.
- Mdc  input  1  management clock, asynchronous to Clk.
- MdioIn  input  1  MDIO pad input.
- MdioOut  output  1  MDIO pad output value.
- MdioOe  output  1  MDIO pad output enable (1 = drive).
- RegAddr  output  5  captured REGAD; held until the next frame's REGAD is complete.
- RegWrData  output  16  captured write data.
- RegWr  output  1  one-Clk write strobe.
- RegRd  output  1  one-Clk read request.
- RegRdData  input  16  register data; valid the Clk after RegRd.
- FrameErr  output  1  one-Clk pulse on a bad ST or OP.

Behaviour:
- Reset (Resetn = 0, asynchronous): all outputs 0, state IDLE, preamble counter 0. MdioOe drops immediately, including mid-read.
- Synchronisation and sampling:
  - Mdc and MdioIn each pass through SYNC_STAGES flops (equal latency).
  - A rise pulse is generated on a synchronised 0->1 Mdc transition, a fall pulse on 1->0.
  - All input bits are sampled on rise pulses only. MdioOut/MdioOe change only on fall pulses, except on reset.
- IDLE:
  - Each sampled 1 increments the preamble counter, saturating at PREAMBLE_LEN.
  - A sampled 0 with counter == PREAMBLE_LEN goes to ST2. A sampled 0 with a short counter clears it and stays in IDLE.
- ST2: sampled 1 -> OP. Sampled 0 -> FrameErr, back to IDLE.
- OP (2 bits):
  - 10 = read, 01 = write.
  - 00 or 11 -> FrameErr, IDLE.
- PHYAD (5 bits, MSB first):
  - On the 5th bit, compare with PhyAddr; with BCAST_EN, 5'h00 also matches.
  - Mismatch -> IDLE silently, no strobes and no drive.
- REGAD (5 bits):
  - On the 5th bit, RegAddr is updated.
  - For a read, RegRd pulses in that same Clk; RegRdData is latched into the 16-bit tx shift register on the following Clk.
- TA (2 bits):
  - Write: sampled values are ignored.
  - Read: MdioOe stays 0 for TA bit 1. On the fall pulse after TA bit 1 is sampled, MdioOe = 1 and MdioOut = 0.
- DATA (16 bits, MSB first):
  - Write: bits shift into RegWrData. On the 16th rise pulse, RegWrData holds the final value and RegWr pulses for one Clk in the same cycle. Then IDLE.
  - Read: on each fall pulse after a TA-bit-2 or data-bit sample, MdioOut = the next tx bit (MSB first). On the fall pulse after data bit 16 is sampled, MdioOe = 0 and MdioOut = 0. Then IDLE.
- After any frame or abort, the preamble counter is 0, so a new preamble is required.
- A bit counter (0..15) is reused per field and clears on each state transition.
- The responder never drives during IDLE, ST2, OP, PHYAD, REGAD, TA bit 1, or any write frame.
- If Mdc stops mid-frame, the state is held indefinitely; only Resetn clears it.
- RegWr and RegRd never assert in the same Clk. There is at most one strobe per frame.

Decomposition:
- eth_mdio_pkg holds:
  - state enum: IDLE, ST2, OP, PHYAD, REGAD, TA, DATA;
  - opcode constants OP_READ = 2'b10, OP_WRITE = 2'b01;
  - ST = 2'b01;
  - field widths 5/5/16.
- One sub-module, eth_mdio_edge_sync: SYNC_STAGES synchroniser for Mdc and MdioIn plus rise/fall pulse generation.

Test Plan:
- Write: 32x1 preamble, 01 01 00001 00011 10, data 16'hA5C3, PhyAddr = 1 -> exactly one RegWr pulse with RegAddr = 5'h03, RegWrData = 16'hA5C3; MdioOe is 0 throughout.
- Read: 32x1, 01 10 00001 00010, RegRdData = 16'h1234 -> RegRd pulses once with RegAddr = 5'h02; MdioOe rises at the fall after TA bit 1; MDIO serialises 0 then 0001001000110100; MdioOe is 0 after data bit 16.
- Wrong PHYAD 00010 with PhyAddr = 1, BCAST_EN = 0 -> no RegWr/RegRd, MdioOe stays 0; a following valid frame is still decoded.
- Short preamble (31 ones) then a valid frame body -> ignored. Bad ST (00) after 32 ones -> FrameErr pulse, IDLE. OP = 11 -> FrameErr.
- Resetn asserted at data bit 8 of a read -> MdioOe = 0 immediately; after release, the next full-preamble frame completes correctly.
- Back-to-back write then read, each with a 32-bit preamble -> two strobes, correct addresses and data; BCAST_EN = 1 with PHYAD 0 -> responds.

Source files
------------

// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: shared state encoding, opcodes and field widths for the MDIO responder
package eth_mdio_pkg;
  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, DATA} state_t;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST = 2'b01;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W = 16;
endpackage

// File: rtl/eth_mdio_edge_sync.sv
// eth_mdio_edge_sync: synchronises Mdc/MdioIn into Clk and produces Mdc rise/fall pulses
module eth_mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic Mdc,
  input  logic MdioIn,
  output logic MdcRise,
  output logic MdcFall,
  output logic MdioSync
);
  logic [SYNC_STAGES-1:0] mdcSr, mdioSr;
  logic mdcPrev;
  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      mdcSr <= '0;
      mdioSr <= '0;
      mdcPrev <= 1'b0;
    end else begin
      mdcSr <= {mdcSr[SYNC_STAGES-2:0], Mdc};
      mdioSr <= {mdioSr[SYNC_STAGES-2:0], MdioIn};
      mdcPrev <= mdcSr[SYNC_STAGES-1];
    end
  assign MdcRise = mdcSr[SYNC_STAGES-1] & ~mdcPrev;
  assign MdcFall = ~mdcSr[SYNC_STAGES-1] & mdcPrev;
  assign MdioSync = mdioSr[SYNC_STAGES-1];
endmodule

// File: rtl/eth_mdio_responder.sv
// eth_mdio_responder: clause-22 MDIO slave turning frames into register strobes and read-back drive
module eth_mdio_responder
  import eth_mdio_pkg::*;
#(
  parameter int PREAMBLE_LEN = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit BCAST_EN = 1'b0
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic [PHYAD_W-1:0] PhyAddr,
  input  logic               Mdc,
  input  logic               MdioIn,
  output logic               MdioOut,
  output logic               MdioOe,
  output logic [REGAD_W-1:0] RegAddr,
  output logic [DATA_W-1:0]  RegWrData,
  output logic               RegWr,
  output logic               RegRd,
  input  logic [DATA_W-1:0]  RegRdData,
  output logic               FrameErr
);
  localparam logic [5:0] PRE = 6'(PREAMBLE_LEN);
  logic rise, fall, bitIn;
  state_t state, stateNx;
  logic [3:0] bitCnt, bitCntNx;
  logic [5:0] preCnt, preCntNx;
  logic [3:0] shReg, shRegNx;
  logic [4:0] shIn;
  logic isRead, isReadNx, rdPend;
  logic [DATA_W-1:0] txShift, txShiftNx, wrDataNx;
  logic [REGAD_W-1:0] addrNx;
  logic wrNx, rdNx, errNx, outNx, oeNx, rdDrive;

  eth_mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .Clk(Clk), .Resetn(Resetn), .Mdc(Mdc), .MdioIn(MdioIn),
    .MdcRise(rise), .MdcFall(fall), .MdioSync(bitIn)
  );

  assign shIn = {shReg, bitIn};
  assign rdDrive = state == DATA && isRead;

  always_comb begin
    stateNx = state;
    bitCntNx = bitCnt;
    preCntNx = preCnt;
    shRegNx = shReg;
    isReadNx = isRead;
    txShiftNx = rdPend ? RegRdData : txShift;
    addrNx = RegAddr;
    wrDataNx = RegWrData;
    wrNx = 1'b0;
    rdNx = 1'b0;
    errNx = 1'b0;
    outNx = MdioOut;
    oeNx = MdioOe;
    if (rise) begin
      shRegNx = shIn[3:0];
      case (state)
        IDLE: begin
          preCntNx = bitIn ? (preCnt == PRE ? preCnt : preCnt + 6'd1) : 6'd0;
          stateNx = (!bitIn && preCnt == PRE) ? ST2 : IDLE;
        end
        ST2: begin
          errNx = {1'b0, bitIn} != ST;
          stateNx = errNx ? IDLE : OP;
        end
        OP: if (bitCnt[0]) begin
          isReadNx = shIn[1:0] == OP_READ;
          errNx = shIn[1:0] != OP_READ && shIn[1:0] != OP_WRITE;
          stateNx = errNx ? IDLE : PHYAD;
        end
        PHYAD: if (bitCnt == 4'(PHYAD_W - 1))
          stateNx = (shIn == PhyAddr || (BCAST_EN && shIn == '0)) ? REGAD : IDLE;
        REGAD: if (bitCnt == 4'(REGAD_W - 1)) begin
          addrNx = shIn;
          rdNx = isRead;
          stateNx = TA;
        end
        TA: stateNx = bitCnt[0] ? DATA : TA;
        DATA: begin
          wrDataNx = isRead ? RegWrData : {RegWrData[DATA_W-2:0], bitIn};
          wrNx = !isRead && bitCnt == 4'(DATA_W - 1);
          stateNx = bitCnt == 4'(DATA_W - 1) ? IDLE : DATA;
        end
        default: stateNx = IDLE;
      endcase
      bitCntNx = (stateNx != state || state == IDLE) ? 4'd0 : bitCnt + 4'd1;
    end else if (fall) begin
      // Turnaround drive starts once TA bit 1 is sampled; data is shifted out MSB first
      oeNx = isRead && ((state == TA && bitCnt[0]) || state == DATA);
      outNx = rdDrive && txShift[DATA_W-1];
      txShiftNx = rdDrive ? {txShift[DATA_W-2:0], 1'b0} : txShift;
    end
  end

  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      bitCnt <= '0;
      preCnt <= '0;
      shReg <= '0;
      isRead <= 1'b0;
      rdPend <= 1'b0;
      txShift <= '0;
      RegAddr <= '0;
      RegWrData <= '0;
      RegWr <= 1'b0;
      RegRd <= 1'b0;
      FrameErr <= 1'b0;
      MdioOut <= 1'b0;
      MdioOe <= 1'b0;
    end else begin
      state <= stateNx;
      bitCnt <= bitCntNx;
      preCnt <= preCntNx;
      shReg <= shRegNx;
      isRead <= isReadNx;
      rdPend <= RegRd;
      txShift <= txShiftNx;
      RegAddr <= addrNx;
      RegWrData <= wrDataNx;
      RegWr <= wrNx;
      RegRd <= rdNx;
      FrameErr <= errNx;
      MdioOut <= outNx;
      MdioOe <= oeNx;
    end
endmodule
